sd_sdram_arb: RTL and testbench

SD_SDRAM_ARB -- requirements
Module: sd_sdram_arb

---
 rtl/sd_sdram_pkg.sv | 6 +
 rtl/sd_wr_fifo.sv | 47 ++++
 rtl/sd_sdram_arb.sv | 133 +++++++++++++
 tb/tb_sd_sdram_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_sdram_pkg.sv
// sd_sdram_pkg: shared FSM state encoding and default burst/frame sizes for the SD-to-SDRAM loader.
package sd_sdram_pkg;
    typedef enum logic [2:0] {IDLE, WR_CMD, WR_BURST, RD_CMD, RD_BURST} state_t;
    localparam int BURST_DEF       = 256;
    localparam int FRAME_WORDS_DEF = 307200;
endpackage

// File: rtl/sd_wr_fifo.sv
// sd_wr_fifo: synchronous first-word-fall-through FIFO buffering SD picture words for SDRAM write bursts.
// Ports: clk/rst (sync, active-high), push_i/data_i write side, pop_i read strobe,
//        data_o head word (combinational), count_o occupancy, full_o/empty_o flags.
module sd_wr_fifo #(
    parameter int DEPTH = 512,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push on full is accepted then.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rp_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk)
        if (do_push) mem[wp_q] <= data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + AW'(1);
            if (do_pop) rp_q <= (rp_q == AW'(DEPTH - 1)) ? '0 : rp_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sd_sdram_arb.sv
// sd_sdram_arb: arbitrates SDRAM write bursts (SD picture load) against read bursts (VGA refill).
// Ports: clk/rst (sync, active-high); sdram_init_done_i gates all grants;
//        sd_valid_i/sd_data_i/pic_read_done_i from the SD reader;
//        wr_req_o/wr_addr_o/wr_len_o/wr_ack_i/wr_data_rd_i/wr_data_o write-burst channel;
//        rd_fill_req_i/vga_frame_start_i/rd_req_o/rd_addr_o/rd_ack_i read-burst channel;
//        burst_done_i ends the active burst; frame_loaded_o/fifo_err_o sticky status.
module sd_sdram_arb
    import sd_sdram_pkg::*;
#(
    parameter int ADDR_W      = 22,
    parameter int BURST       = BURST_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int FIFO_DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdram_init_done_i,
    input  logic              sd_valid_i,
    input  logic [15:0]       sd_data_i,
    input  logic              pic_read_done_i,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [8:0]        wr_len_o,
    input  logic              wr_ack_i,
    input  logic              wr_data_rd_i,
    output logic [15:0]       wr_data_o,
    input  logic              rd_fill_req_i,
    input  logic              vga_frame_start_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_ack_i,
    input  logic              burst_done_i,
    output logic              frame_loaded_o,
    output logic              fifo_err_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_full, fifo_empty, push, push_err, pop_err;
    logic              w_elig, r_elig, arb_ok, grant_w, grant_r;
    logic              wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic              last_rd_q, last_rd_d, pend_q, pend_d;
    logic              loaded_q, loaded_d, err_q, err_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, rd_next;
    logic [8:0]        wr_len_q, wr_len_d;

    // Once the picture is in SDRAM the SD side is ignored entirely.
    assign push = sd_valid_i && !loaded_q;

    sd_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .data_i (sd_data_i),
        .pop_i  (wr_data_rd_i),
        .data_o (wr_data_o),
        .count_o(fifo_cnt),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign push_err = push && fifo_full && !wr_data_rd_i;
    assign pop_err  = wr_data_rd_i && fifo_empty;
    assign w_elig   = !loaded_q && (fifo_cnt >= CW'(BURST) || (pic_read_done_i && !fifo_empty));
    assign r_elig   = rd_fill_req_i;
    assign arb_ok   = state_q == IDLE && sdram_init_done_i;
    // On contention the side that did not win last time is served.
    assign grant_w  = arb_ok && w_elig && (!r_elig || last_rd_q);
    assign grant_r  = arb_ok && r_elig && (!w_elig || !last_rd_q);
    assign rd_next  = rd_addr_q + ADDR_W'(BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_len_q  <= '0;
            last_rd_q <= 1'b0;
            pend_q    <= 1'b0;
            loaded_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_len_q  <= wr_len_d;
            last_rd_q <= last_rd_d;
            pend_q    <= pend_d;
            loaded_q  <= loaded_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = grant_w ? WR_CMD : grant_r ? RD_CMD : IDLE;
            WR_CMD:   state_d = wr_ack_i ? WR_BURST : WR_CMD;
            WR_BURST: state_d = burst_done_i ? IDLE : WR_BURST;
            RD_CMD:   state_d = rd_ack_i ? RD_BURST : RD_CMD;
            RD_BURST: state_d = burst_done_i ? IDLE : RD_BURST;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_req_d  = state_d == WR_CMD;
        rd_req_d  = state_d == RD_CMD;
        wr_len_d  = grant_w ? (fifo_cnt >= CW'(BURST) ? 9'(BURST) : 9'(fifo_cnt)) : wr_len_q;
        wr_addr_d = (state_q == WR_BURST && burst_done_i) ? wr_addr_q + ADDR_W'(wr_len_q) : wr_addr_q;
        // A frame restart only takes effect between bursts so an active read is never disturbed.
        rd_addr_d = (state_q == RD_BURST && burst_done_i) ? (rd_next >= ADDR_W'(FRAME_WORDS) ? '0 : rd_next)
                  : (state_q == IDLE && pend_q) ? '0 : rd_addr_q;
        pend_d    = vga_frame_start_i || (pend_q && state_q != IDLE);
        last_rd_d = grant_r ? 1'b1 : grant_w ? 1'b0 : last_rd_q;
        loaded_d  = loaded_q || wr_addr_q >= ADDR_W'(FRAME_WORDS)
                  || (pic_read_done_i && fifo_empty && state_q == IDLE);
        err_d     = err_q || push_err || pop_err;
    end

    assign wr_req_o       = wr_req_q;
    assign rd_req_o       = rd_req_q;
    assign wr_addr_o      = wr_addr_q;
    assign rd_addr_o      = rd_addr_q;
    assign wr_len_o       = wr_len_q;
    assign frame_loaded_o = loaded_q;
    assign fifo_err_o     = err_q;
endmodule

// File: tb/tb_sd_sdram_arb.sv
// tb_sd_sdram_arb: directed-sequence bench with random data/handshake delays against a queue-based model.
module tb_sd_sdram_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        sdram_init_done_i, sd_valid_i, pic_read_done_i;
    logic [15:0] sd_data_i;
    logic        wr_req_o, wr_ack_i, wr_data_rd_i;
    logic [21:0] wr_addr_o, rd_addr_o;
    logic [8:0]  wr_len_o;
    logic [15:0] wr_data_o;
    logic        rd_fill_req_i, vga_frame_start_i, rd_req_o, rd_ack_i, burst_done_i;
    logic        frame_loaded_o, fifo_err_o;

    int          total = 0;
    int          bad = 0;
    logic [15:0] m_q[$];
    int          m_wr_addr, m_rd_addr;
    bit          m_loaded, m_err;
    int          side;

    always #5 clk = ~clk;

    sd_sdram_arb dut (
        .clk              (clk),
        .rst              (rst),
        .sdram_init_done_i(sdram_init_done_i),
        .sd_valid_i       (sd_valid_i),
        .sd_data_i        (sd_data_i),
        .pic_read_done_i  (pic_read_done_i),
        .wr_req_o         (wr_req_o),
        .wr_addr_o        (wr_addr_o),
        .wr_len_o         (wr_len_o),
        .wr_ack_i         (wr_ack_i),
        .wr_data_rd_i     (wr_data_rd_i),
        .wr_data_o        (wr_data_o),
        .rd_fill_req_i    (rd_fill_req_i),
        .vga_frame_start_i(vga_frame_start_i),
        .rd_req_o         (rd_req_o),
        .rd_addr_o        (rd_addr_o),
        .rd_ack_i         (rd_ack_i),
        .burst_done_i     (burst_done_i),
        .frame_loaded_o   (frame_loaded_o),
        .fifo_err_o       (fifo_err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        sdram_init_done_i = 1'b1;
        {sd_valid_i, pic_read_done_i, wr_ack_i, wr_data_rd_i} = '0;
        {rd_fill_req_i, vga_frame_start_i, rd_ack_i, burst_done_i} = '0;
        sd_data_i = '0;
        tick();
        tick();
        rst = 1'b0;
        m_q.delete();
        m_wr_addr = 0;
        m_rd_addr = 0;
        m_loaded = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic push_n(input int n);
        logic [15:0] d;
        sd_valid_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
            sd_data_i = d;
            if (!m_loaded && m_q.size() < 512) m_q.push_back(d);
            else if (!m_loaded) m_err = 1'b1;
            tick();
        end
        sd_valid_i = 1'b0;
    endtask

    // 1 = write request, 2 = read request, 3 = both (illegal), 0 = timeout.
    task automatic wait_any(output int s);
        int k;
        k = 0;
        while (!(wr_req_o || rd_req_o) && k < 100) begin
            tick();
            k++;
        end
        s = (wr_req_o && rd_req_o) ? 3 : wr_req_o ? 1 : rd_req_o ? 2 : 0;
    endtask

    task automatic serve_write(input bit ap);
        int s, n;
        logic [15:0] d;
        wait_any(s);
        chk("wr_grant", s, 1);
        n = m_q.size() < 256 ? m_q.size() : 256;
        chk("wr_addr", wr_addr_o, m_wr_addr);
        chk("wr_len", wr_len_o, n);
        repeat ($urandom_range(0, 2)) tick();
        chk("wr_req_hold", wr_req_o, 1);
        wr_ack_i = 1'b1;
        tick();
        wr_ack_i = 1'b0;
        chk("wr_req_drop", wr_req_o, 0);
        wr_data_rd_i = 1'b1;
        sd_valid_i = ap;
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
            sd_data_i = d;
            chk("wr_data", wr_data_o, m_q.pop_front());
            if (ap) m_q.push_back(d);
            tick();
        end
        wr_data_rd_i = 1'b0;
        sd_valid_i = 1'b0;
        burst_done_i = 1'b1;
        tick();
        burst_done_i = 1'b0;
        m_wr_addr += n;
        chk("wr_addr_adv", wr_addr_o, m_wr_addr);
    endtask

    task automatic serve_read();
        int s;
        wait_any(s);
        chk("rd_grant", s, 2);
        chk("rd_addr", rd_addr_o, m_rd_addr);
        repeat ($urandom_range(0, 2)) tick();
        rd_ack_i = 1'b1;
        tick();
        rd_ack_i = 1'b0;
        chk("rd_req_drop", rd_req_o, 0);
        repeat ($urandom_range(0, 2)) tick();
        burst_done_i = 1'b1;
        tick();
        burst_done_i = 1'b0;
        m_rd_addr = (m_rd_addr + 256 >= 307200) ? 0 : m_rd_addr + 256;
        chk("rd_addr_adv", rd_addr_o, m_rd_addr);
    endtask

    initial begin
        // Reset state
        reset_dut();
        chk("rst_wr_req", wr_req_o, 0);
        chk("rst_rd_req", rd_req_o, 0);
        chk("rst_wr_addr", wr_addr_o, 0);
        chk("rst_rd_addr", rd_addr_o, 0);
        chk("rst_wr_len", wr_len_o, 0);
        chk("rst_loaded", frame_loaded_o, 0);
        chk("rst_err", fifo_err_o, 0);

        // Full 256-word write burst
        push_n(256);
        serve_write(1'b0);
        chk("t1_rd_req", rd_req_o, 0);
        chk("t1_count", dut.fifo_cnt, 0);

        // Alternating grants under contention
        reset_dut();
        push_n(256);
        wait_any(side);
        chk("t2_first", side, 1);
        rd_fill_req_i = 1'b1;
        serve_write(1'b1);
        serve_read();
        serve_write(1'b1);
        serve_read();
        rd_fill_req_i = 1'b0;
        chk("t2_count", dut.fifo_cnt, m_q.size());
        chk("t2_err", fifo_err_o, 0);

        // Short final burst and frame_loaded
        reset_dut();
        push_n(100);
        repeat (5) tick();
        chk("t3_no_req", wr_req_o, 0);
        pic_read_done_i = 1'b1;
        serve_write(1'b0);
        tick();
        chk("t3_loaded", frame_loaded_o, 1);
        m_loaded = 1'b1;
        push_n(5);
        chk("t3_ignored", dut.fifo_cnt, 0);
        chk("t3_err", fifo_err_o, 0);
        repeat (3) tick();
        chk("t3_no_req2", wr_req_o, 0);
        pic_read_done_i = 1'b0;

        // Pop on empty
        reset_dut();
        wr_data_rd_i = 1'b1;
        tick();
        wr_data_rd_i = 1'b0;
        chk("t4_pop_err", fifo_err_o, 1);
        chk("t4_count", dut.fifo_cnt, 0);

        // Overflow, drain, underflow
        reset_dut();
        sdram_init_done_i = 1'b0;
        push_n(512);
        chk("t5_count_full", dut.fifo_cnt, 512);
        chk("t5_err_before", fifo_err_o, m_err);
        push_n(1);
        chk("t5_count_ovf", dut.fifo_cnt, 512);
        chk("t5_err_ovf", fifo_err_o, m_err);
        chk("t5_no_req", wr_req_o, 0);
        wr_data_rd_i = 1'b1;
        for (int i = 0; i < 512; i++) begin
            chk("t5_data", wr_data_o, m_q.pop_front());
            tick();
        end
        tick();
        wr_data_rd_i = 1'b0;
        chk("t5_count_empty", dut.fifo_cnt, 0);
        chk("t5_err_sticky", fifo_err_o, 1);

        // Read address wrap and frame restart
        reset_dut();
        rd_fill_req_i = 1'b1;
        while (m_rd_addr != 306944) serve_read();
        serve_read();
        chk("t6_wrapped", rd_addr_o, 0);
        serve_read();
        wait_any(side);
        chk("t6_grant", side, 2);
        chk("t6_addr", rd_addr_o, 256);
        rd_ack_i = 1'b1;
        tick();
        rd_ack_i = 1'b0;
        vga_frame_start_i = 1'b1;
        tick();
        vga_frame_start_i = 1'b0;
        tick();
        chk("t6_mid_burst", rd_addr_o, 256);
        burst_done_i = 1'b1;
        tick();
        burst_done_i = 1'b0;
        chk("t6_after_done", rd_addr_o, 512);
        tick();
        chk("t6_restart", rd_addr_o, 0);
        m_rd_addr = 0;
        serve_read();
        rd_fill_req_i = 1'b0;

        // Reset during a write burst, then gated by init_done
        reset_dut();
        push_n(256);
        wait_any(side);
        chk("t7_grant", side, 1);
        wr_ack_i = 1'b1;
        tick();
        wr_ack_i = 1'b0;
        wr_data_rd_i = 1'b1;
        repeat (10) tick();
        wr_data_rd_i = 1'b0;
        rst = 1'b1;
        tick();
        chk("t7_wr_req", wr_req_o, 0);
        chk("t7_wr_addr", wr_addr_o, 0);
        chk("t7_wr_len", wr_len_o, 0);
        chk("t7_count", dut.fifo_cnt, 0);
        sdram_init_done_i = 1'b0;
        tick();
        rst = 1'b0;
        m_q.delete();
        m_wr_addr = 0;
        m_rd_addr = 0;
        rd_fill_req_i = 1'b1;
        push_n(300);
        repeat (10) tick();
        chk("t7_no_wr", wr_req_o, 0);
        chk("t7_no_rd", rd_req_o, 0);
        wr_ack_i = 1'b1;
        tick();
        wr_ack_i = 1'b0;
        rd_ack_i = 1'b1;
        tick();
        rd_ack_i = 1'b0;
        burst_done_i = 1'b1;
        tick();
        burst_done_i = 1'b0;
        chk("t7_stray_wr", wr_addr_o, 0);
        chk("t7_stray_rd", rd_addr_o, 0);
        sdram_init_done_i = 1'b1;
        serve_read();
        rd_fill_req_i = 1'b0;
        serve_write(1'b0);
        chk("t7_err", fifo_err_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
